// File: rtl/modport_fifo_pkg.sv
// -----------------------------------------------------------------------------
// modport_fifo_pkg
// Shared defaults for the synchronous FIFO: data width, depth, almost-full and
// almost-empty thresholds, and the pointer width derived from the depth.
// -----------------------------------------------------------------------------
package modport_fifo_pkg;

    localparam int DATA_W_DEF       = 128;
    localparam int DEPTH_DEF        = 16;
    // Almost-full sits this many entries below full unless overridden.
    localparam int ALM_FULL_MARGIN  = 2;
    localparam int ALM_FULL_TH_DEF  = DEPTH_DEF - ALM_FULL_MARGIN;
    localparam int ALM_EMPTY_TH_DEF = 2;

    // Pointer width for a power-of-two depth; the occupancy counter is one wider.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);

endpackage

// File: rtl/modport_fifo_mem.sv
// -----------------------------------------------------------------------------
// modport_fifo_mem
// Simple dual-port storage: one write port, one registered read port.
// Ports:
//   clk        clock
//   i_wr_en    write strobe, i_wr_data stored at i_wr_addr
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_en    read strobe, o_rd_data loads entry at i_rd_addr
//   i_rd_addr  read address
//   o_rd_data  registered read data, holds when i_rd_en is low
// -----------------------------------------------------------------------------
module modport_fifo_mem
    import modport_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PTR_W  = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [PTR_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [PTR_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // NOTE: storage has no reset on purpose; stale contents are unreachable
    // once the pointers are cleared, and leaving it out keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/modport_fifo.sv
// -----------------------------------------------------------------------------
// modport_fifo
// Synchronous single-clock FIFO with registered read data and registered
// full / empty / almost-full / almost-empty flags.
// Ports:
//   clk          clock, rising edge
//   rstn         synchronous reset, active HIGH despite the name
//   i_wren       write request, dropped while full
//   i_rden       read request, ignored while empty
//   i_wrdata     write data
//   o_rddata     read data, one cycle after an accepted read
//   o_full       occupancy == DEPTH
//   o_empty      occupancy == 0
//   o_alm_full   occupancy >= ALM_FULL_TH
//   o_alm_empty  occupancy <= ALM_EMPTY_TH
// -----------------------------------------------------------------------------
module modport_fifo
    import modport_fifo_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int ALM_FULL_TH  = DEPTH - ALM_FULL_MARGIN,
    parameter int ALM_EMPTY_TH = ALM_EMPTY_TH_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_wren,
    input  logic              i_rden,
    input  logic [DATA_W-1:0] i_wrdata,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ALM_FULL_C  = CNT_W'(ALM_FULL_TH);
    localparam logic [CNT_W-1:0] ALM_EMPTY_C = CNT_W'(ALM_EMPTY_TH);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_alm_full;
    logic              r_alm_empty;
    // Forces o_rddata to zero from reset until the first accepted read, since
    // the memory's read register itself carries no reset.
    logic              r_rd_zero;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_mem_rddata;

    // Reset masks both requests so the memory is not touched during reset.
    assign w_wr_acc = i_wren && !r_full  && !rstn;
    assign w_rd_acc = i_rden && !r_empty && !rstn;

    // NOTE: default assignment first so every path drives w_count_nxt and no
    // latch is inferred.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_alm_full  <= 1'b0;
            r_alm_empty <= 1'b1;
            r_rd_zero   <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                r_rd_zero <= 1'b0;
            end
            // Flags come from the updated occupancy so they line up with it.
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == DEPTH_C);
            r_empty     <= (w_count_nxt == '0);
            r_alm_full  <= (w_count_nxt >= ALM_FULL_C);
            r_alm_empty <= (w_count_nxt <= ALM_EMPTY_C);
        end
    end

    modport_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_wrdata),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rddata)
    );

    assign o_rddata    = r_rd_zero ? '0 : w_mem_rddata;
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_alm_full  = r_alm_full;
    assign o_alm_empty = r_alm_empty;

endmodule

// File: tb/tb_modport_fifo.sv
// -----------------------------------------------------------------------------
// tb_modport_fifo
// Directed test of modport_fifo at default parameters (DATA_W=128, DEPTH=16,
// ALM_FULL_TH=14, ALM_EMPTY_TH=2). Expected values are written out by hand
// and the bench tracks the expected occupancy itself to predict the flags.
// -----------------------------------------------------------------------------
module tb_modport_fifo;

    localparam int DW = 128;

    logic          clk;
    logic          rstn;
    logic          i_wren;
    logic          i_rden;
    logic [DW-1:0] i_wrdata;
    logic [DW-1:0] o_rddata;
    logic          o_full;
    logic          o_empty;
    logic          o_alm_full;
    logic          o_alm_empty;

    int errors;
    int checks;
    int exp_cnt;

    modport_fifo dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_wren      (i_wren),
        .i_rden      (i_rden),
        .i_wrdata    (i_wrdata),
        .o_rddata    (o_rddata),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_alm_full  (o_alm_full),
        .o_alm_empty (o_alm_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flag expectations from the bench's own occupancy count.
    task automatic check_flags(input string tag, input int cnt);
        check({tag, ".full"},      DW'(o_full),      DW'(cnt == 16));
        check({tag, ".empty"},     DW'(o_empty),     DW'(cnt == 0));
        check({tag, ".alm_full"},  DW'(o_alm_full),  DW'(cnt >= 14));
        check({tag, ".alm_empty"}, DW'(o_alm_empty), DW'(cnt <= 2));
    endtask

    // One clock with the given request inputs; outputs are then sampled 1ns
    // after the edge and the requests dropped.
    task automatic cyc(input logic wr, input logic rd, input logic [DW-1:0] d);
        i_wren   = wr;
        i_rden   = rd;
        i_wrdata = d;
        @(posedge clk);
        #1;
        i_wren   = 1'b0;
        i_rden   = 1'b0;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        exp_cnt  = 0;
        rstn     = 1'b1;
        i_wren   = 1'b0;
        i_rden   = 1'b0;
        i_wrdata = '0;

        // Reset state
        @(posedge clk);
        #1;
        rstn = 1'b0;
        check_flags("reset", 0);
        check("reset.rddata", o_rddata, '0);

        // Write 1..3 then read them back in order
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 1'b0, DW'(i));
            check_flags($sformatf("wr3.%0d", i), i);
        end
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b1, '0);
            check($sformatf("rd3.%0d", i), o_rddata, DW'(i));
            check_flags($sformatf("rd3.%0d", i), 3 - i);
        end

        // Read while empty: data holds, still empty
        cyc(1'b0, 1'b1, '0);
        check("rd_empty.rddata", o_rddata, DW'(3));
        check_flags("rd_empty", 0);

        // Fill to 16, then a dropped 17th write
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, DW'('h100 + i));
            check_flags($sformatf("fill.%0d", i + 1), i + 1);
        end
        cyc(1'b1, 1'b0, DW'('hDEAD));
        check_flags("wr_full", 16);
        check("wr_full.rddata", o_rddata, DW'(3));

        // Read and write together while full: only the read goes through
        cyc(1'b1, 1'b1, DW'('hBEEF));
        check("rdwr_full.rddata", o_rddata, DW'('h100));
        check_flags("rdwr_full", 15);

        // Drain the rest in order; 0xDEAD and 0xBEEF must not appear
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 1'b1, '0);
            check($sformatf("drain.%0d", i), o_rddata, DW'('h100 + i));
            check_flags($sformatf("drain.%0d", i), 15 - i);
        end

        // Count 5, then 20 cycles of simultaneous read and write across the wrap
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, DW'('h200 + i));
        end
        check_flags("pre_stream", 5);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 1'b1, DW'('h300 + k));
            check($sformatf("stream.%0d", k), o_rddata,
                  (k < 5) ? DW'('h200 + k) : DW'('h300 + k - 5));
            check_flags($sformatf("stream.%0d", k), 5);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, '0);
            check($sformatf("post_stream.%0d", i), o_rddata, DW'('h30F + i));
        end
        check_flags("post_stream", 0);

        // Read and write together while empty: only the write goes through
        cyc(1'b1, 1'b1, DW'('hABC));
        check("rdwr_empty.rddata", o_rddata, DW'('h313));
        check_flags("rdwr_empty", 1);
        cyc(1'b0, 1'b1, '0);
        check("rdwr_empty.readback", o_rddata, DW'('hABC));
        check_flags("rdwr_empty.readback", 0);

        // Reset with 10 entries stored and both requests active
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, DW'('h400 + i));
        end
        check_flags("pre_reset", 10);
        rstn = 1'b1;
        cyc(1'b1, 1'b1, DW'('h555));
        rstn = 1'b0;
        check_flags("mid_reset", 0);
        check("mid_reset.rddata", o_rddata, '0);

        // Stored data is gone: a read is ignored and data stays zero
        cyc(1'b0, 1'b1, '0);
        check("post_reset_rd.rddata", o_rddata, '0);
        check_flags("post_reset_rd", 0);

        exp_cnt = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
